// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_encoder: assembles RV32I words from fields, with legality checks.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module instr_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          iword,
  output logic                 out_err,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 cnt_clr
);

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_REG    = 7'b0110011;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  localparam logic [1:0] C_ERR_NONE  = 2'b00;
  localparam logic [1:0] C_ERR_RANGE = 2'b01;
  localparam logic [1:0] C_ERR_MISAL = 2'b10;
  localparam logic [1:0] C_ERR_OPC   = 2'b11;

  // True when v equals the sign-extension of its low n bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] sh;
    sh = $signed(v) >>> (n - 1);
    return (sh == 32'h0) || (sh == 32'hFFFF_FFFF);
  endfunction

  // Stage 1: captured request fields
  logic        s1_valid_q, s1_valid_d;
  logic [6:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [2:0]  f3_q, f3_d;
  logic [6:0]  f7_q, f7_d;
  logic [31:0] imm_q, imm_d;

  // Stage 2: encoded result
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] iword_q, iword_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic        s2_free;
  logic [31:0] enc_word;
  logic [1:0]  enc_code;

  always_comb begin
    enc_word = 32'h0;
    enc_code = C_ERR_NONE;
    case (op_q)
      C_OP_LOAD, C_OP_JALR, C_OP_SYSTEM: begin
        enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
        if (!fits_signed(imm_q, 12)) enc_code = C_ERR_RANGE;
      end
      C_OP_IMM: begin
        if (f3_q == 3'b001 || f3_q == 3'b101) begin
          enc_word = {f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, op_q};
          if (imm_q[31:5] != 27'h0) enc_code = C_ERR_RANGE;
        end else begin
          enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
          if (!fits_signed(imm_q, 12)) enc_code = C_ERR_RANGE;
        end
      end
      C_OP_STORE: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
        if (!fits_signed(imm_q, 12)) enc_code = C_ERR_RANGE;
      end
      C_OP_BRANCH: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                    imm_q[4:1], imm_q[11], op_q};
        if (imm_q[0]) enc_code = C_ERR_MISAL;
        else if (!fits_signed(imm_q, 13)) enc_code = C_ERR_RANGE;
      end
      C_OP_LUI, C_OP_AUIPC: begin
        enc_word = {imm_q[31:12], rd_q, op_q};
        if (imm_q[11:0] != 12'h0) enc_code = C_ERR_RANGE;
      end
      C_OP_JAL: begin
        enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
        if (imm_q[0]) enc_code = C_ERR_MISAL;
        else if (!fits_signed(imm_q, 21)) enc_code = C_ERR_RANGE;
      end
      C_OP_REG: begin
        enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
      end
      default: enc_code = C_ERR_OPC;
    endcase
    if (enc_code != C_ERR_NONE) enc_word = C_NOP;
  end

  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_free;

    s1_valid_d = s1_valid_q;
    op_d  = op_q;
    rd_d  = rd_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    f3_d  = f3_q;
    f7_d  = f7_q;
    imm_d = imm_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        op_d  = opcode;
        rd_d  = rd;
        rs1_d = rs1;
        rs2_d = rs2;
        f3_d  = funct3;
        f7_d  = funct7;
        imm_d = imm;
      end
    end

    // Output fields only change when the held word has left or S2 was empty.
    s2_valid_d = s2_valid_q;
    iword_d    = iword_q;
    err_d      = err_q;
    code_d     = code_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        iword_d = enc_word;
        err_d   = (enc_code != C_ERR_NONE);
        code_d  = enc_code;
      end
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && err_q && (cnt_q != {ERR_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      op_q       <= 7'h0;
      rd_q       <= 5'h0;
      rs1_q      <= 5'h0;
      rs2_q      <= 5'h0;
      f3_q       <= 3'h0;
      f7_q       <= 7'h0;
      imm_q      <= 32'h0;
      s2_valid_q <= 1'b0;
      iword_q    <= 32'h0;
      err_q      <= 1'b0;
      code_q     <= C_ERR_NONE;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      f3_q       <= f3_d;
      f7_q       <= f7_d;
      imm_q      <= imm_d;
      s2_valid_q <= s2_valid_d;
      iword_q    <= iword_d;
      err_q      <= err_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign iword     = iword_q;
  assign out_err   = err_q;
  assign err_code  = code_q;
  assign err_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_encoder: directed self-checking bench for instr_encoder.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] iword;
  logic        out_err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic        cnt_clr;

  instr_encoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .iword(iword), .out_err(out_err), .err_code(err_code),
    .err_count(err_count), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] w;
    logic        e;
    logic [1:0]  c;
  } vec_t;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   acc_cnt = 0;
  vec_t q[$];

  always @(posedge clk) if (!rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] im, input logic [31:0] w, input logic [1:0] c);
    vec_t v;
    v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f3; v.f7 = f7; v.imm = im;
    v.w = w; v.c = c; v.e = (c != 2'b00);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Streams q with out_ready=1; word k is visible two cycles after it is offered.
  task automatic run_batch(input string tag);
    int n;
    vec_t v;
    n = q.size();
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) drive(q[c]); else idle();
      if (c >= 2) begin
        v = q[c-2];
        check($sformatf("%s[%0d].out_valid", tag, c-2), {31'h0, out_valid}, 32'h1);
        check($sformatf("%s[%0d].iword", tag, c-2), iword, v.w);
        check($sformatf("%s[%0d].out_err", tag, c-2), {31'h0, out_err}, {31'h0, v.e});
        check($sformatf("%s[%0d].err_code", tag, c-2), {30'h0, err_code}, {30'h0, v.c});
      end
      tick();
    end
    check($sformatf("%s.drained", tag), {31'h0, out_valid}, 32'h0);
    q.delete();
  endtask

  vec_t bp[4];
  vec_t bad;
  int   idx;
  int   acc0;
  logic acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    bad = mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 32'h0000_0013, 2'b11);

    // Reset state
    repeat (3) tick();
    check("rst.in_ready", {31'h0, in_ready}, 32'h1);
    check("rst.out_valid", {31'h0, out_valid}, 32'h0);
    check("rst.iword", iword, 32'h0);
    check("rst.out_err", {31'h0, out_err}, 32'h0);
    check("rst.err_code", {30'h0, err_code}, 32'h0);
    check("rst.err_count", {24'h0, err_count}, 32'h0);
    rst = 1'b0;
    tick();

    // addi x1,x0,-1: latency of exactly two cycles
    drive(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'b00));
    check("addi.in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    idle();
    check("addi.lat1", {31'h0, out_valid}, 32'h0);
    tick();
    check("addi.lat2", {31'h0, out_valid}, 32'h1);
    check("addi.iword", iword, 32'hFFF0_0093);
    check("addi.out_err", {31'h0, out_err}, 32'h0);
    tick();
    check("addi.done", {31'h0, out_valid}, 32'h0);

    // Back-to-back legal words
    q.push_back(mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 2'b00));
    q.push_back(mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'b00));
    q.push_back(mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 2'b00));
    q.push_back(mk(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'b00));
    run_batch("b2b");

    // Error words
    q.push_back(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 2'b01));
    q.push_back(mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0013, 2'b10));
    q.push_back(mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0013, 2'b11));
    run_batch("err");
    check("err.count3", {24'h0, err_count}, 32'd3);

    // Shifts, R-type, U/J range and priority corners
    q.push_back(mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3, 32'h4031_5093, 2'b00));
    q.push_back(mk(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 2'b00));
    q.push_back(mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd32, 32'h0000_0013, 2'b01));
    q.push_back(mk(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 2'b01));
    q.push_back(mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0000_0013, 2'b10));
    q.push_back(mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0000_0013, 2'b01));
    q.push_back(mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_2001, 32'h0000_0013, 2'b10));
    run_batch("misc");
    check("misc.count8", {24'h0, err_count}, 32'd8);

    // Backpressure: only two requests fit while the consumer stalls
    bp[0] = mk(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0193, 2'b00);
    bp[1] = mk(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'b00);
    bp[2] = mk(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h0020_81B3, 2'b00);
    bp[3] = bp[2];
    out_ready = 1'b0;
    acc0 = acc_cnt;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      drive(bp[idx]);
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    check("bp.accepted", acc_cnt - acc0, 32'd2);
    check("bp.in_ready", {31'h0, in_ready}, 32'h0);
    check("bp.iword", iword, bp[0].w);
    tick();
    check("bp.stable", iword, bp[0].w);
    check("bp.still_valid", {31'h0, out_valid}, 32'h1);
    idle();
    out_ready = 1'b1;
    check("bp.out0", iword, bp[0].w);
    tick();
    check("bp.out1", iword, bp[1].w);
    check("bp.out1_valid", {31'h0, out_valid}, 32'h1);
    tick();
    check("bp.drained", {31'h0, out_valid}, 32'h0);

    // Saturation
    for (int k = 0; k < 255; k++) begin
      drive(bad);
      tick();
    end
    idle();
    repeat (3) tick();
    check("sat.count255", {24'h0, err_count}, 32'd255);
    q.push_back(bad);
    run_batch("sat1");
    check("sat.hold255", {24'h0, err_count}, 32'd255);

    // Clear collides with an error transfer
    drive(bad);
    tick();
    idle();
    tick();
    check("clr.err_pending", {31'h0, out_err}, 32'h1);
    check("clr.before", {24'h0, err_count}, 32'd255);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr.after", {24'h0, err_count}, 32'd0);

    // One counted error, then a stalled error that must not count
    q.push_back(bad);
    run_batch("one");
    check("one.count1", {24'h0, err_count}, 32'd1);
    out_ready = 1'b0;
    drive(bad);
    tick();
    drive(bp[0]);
    tick();
    idle();
    repeat (2) tick();
    check("stall.out_err", {31'h0, out_err}, 32'h1);
    check("stall.in_ready", {31'h0, in_ready}, 32'h0);
    check("stall.count", {24'h0, err_count}, 32'd1);

    // Reset with both stages full
    rst = 1'b1;
    tick();
    check("rst2.out_valid", {31'h0, out_valid}, 32'h0);
    check("rst2.in_ready", {31'h0, in_ready}, 32'h1);
    check("rst2.err_count", {24'h0, err_count}, 32'd0);
    check("rst2.iword", iword, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst2.no_stale%0d", k), {31'h0, out_valid}, 32'h0);
    end
    q.push_back(bp[2]);
    run_batch("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate decode: assembles a 32-bit RV32I instruction word from opcode, register, funct and immediate fields.
- Used by the debug/boot injection path to build instructions for the fetch stage.
- Two-stage valid/ready pipeline with immediate legality checking and a saturating error counter.
- Accepted, non-error output decodes back to the supplied immediate through the core's immediate decode.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request
- opcode  in  7  instruction opcode
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R-type and I-type shifts)
- imm  in  32  signed/raw immediate value
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- iword  out  32  encoded instruction
- out_err  out  1  request was illegal
- err_code  out  2  00 none, 01 range, 10 misaligned, 11 bad opcode
- err_count  out  ERR_CNT_W  saturating count of errored words delivered
- cnt_clr  in  1  synchronous clear of err_count

Behaviour:
- Reset: in_ready=1, out_valid=0, iword=0, out_err=0, err_code=00, err_count=0, both stages empty. Reset mid-transfer drops all in-flight requests.
- Handshakes:
  - Input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
  - S1 registers the fields. S2 registers the encoded word and error fields.
  - S1 advances when S2 is empty or S2 transfers in the same cycle. in_ready = !S1_valid || S1 advances.
  - Accept-to-out_valid latency is exactly 2 cycles. Sustained throughput is 1/cycle with out_ready=1.
  - While out_valid=1 and out_ready=0, iword/out_err/err_code hold stable.
- Encoding (combinational from S1, registered into S2):
  - I (0000011, 0010011, 1100111, 1110011): {imm[11:0],rs1,funct3,rd,opcode}. Legal iff imm in [-2048,2047].
  - Shift exception (opcode 0010011, funct3 001/101): {funct7,imm[4:0],rs1,funct3,rd,opcode}. Legal iff imm in [0,31].
  - S (0100011): {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}. Range [-2048,2047].
  - B (1100011): {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
    - imm[0]!=0 → misaligned.
    - Else legal iff imm in [-4096,4094].
  - U (0110111, 0010111): {imm[31:12],rd,opcode}. imm[11:0]!=0 → range error.
  - J (1101111): {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
    - imm[0]!=0 → misaligned.
    - Else range [-1048576,1048574].
  - R (0110011): {funct7,rs2,rs1,funct3,rd,opcode}. imm ignored, never errors.
  - Any other opcode → bad opcode.
- Range check is two's-complement: imm must equal sign-extension of its low N bits.
- Error priority: bad opcode > misaligned > range.
- On any error: iword=32'h00000013 (NOP), out_err=1, err_code set.
- err_count:
  - Increments by 1 on each output transfer with out_err=1.
  - Saturates at all-ones with no wrap.
  - cnt_clr sets it to 0; clear wins over a simultaneous increment.
  - Stalled (not-yet-transferred) errors are not counted.

Test Plan:
- addi x1,x0,-1 (opcode 0010011, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF) → iword 0xFFF00093 two cycles after accept, out_err=0.
- Back-to-back, out_ready=1:
  - sw x2,8(x1) → 0x0020A423.
  - beq x0,x0,-4 → 0xFE000EE3.
  - jal x1,2048 → 0x001000EF.
  - lui x5 imm=0x12345000 → 0x123452B7.
  - Expect one word per cycle, in order.
- Errors:
  - addi imm=2048 → 0x00000013, err_code=01.
  - beq imm=3 → err_code=10.
  - opcode 0x7F → err_code=11.
  - err_count=3 after all three transfer.
- Backpressure: out_ready=0, in_valid held for 4 requests → exactly 2 accepted, in_ready=0, iword stable. Release out_ready → words emitted in order, nothing lost or duplicated.
- err_count=255 plus another error → stays 255. cnt_clr on the same cycle as an error transfer → 0.
- rst asserted with both stages full → next cycle out_valid=0, in_ready=1, err_count=0. Stale words never appear.
